uart_rx: RTL and testbench

8N1 UART receiver: the stage directly downstream of uart_tx, consuming the serial line that uart_tx drives on sout. Synchronises the asynchronous serial input and detects the start bit. Samples each bit at its centre and presents the received byte in parallel with a one-cycle valid strobe. Flags framing errors and tracks busy status, mirroring uart_tx's busy_tx.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding, used by uart_tx and uart_rx.
package uart_pkg;
  localparam int   DATA_BITS        = 8;
  localparam int   CLKS_PER_BIT_DEF = 8;
  localparam logic IDLE_LVL         = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial input plus the parallel byte/status outputs.
interface uart_rx_if;
  import uart_pkg::*;
  logic                 sin;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_valid;
  logic                 busy_rx;
  logic                 frame_err;

  modport master (input sin, output dout, rx_valid, busy_rx, frame_err);
  modport slave  (output sin, input dout, rx_valid, busy_rx, frame_err);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset level set by RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre-of-bit sampling, framing-error flag and break hold-off.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity checked before the stop bit).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       fpga_clk,
  input  logic       nrst,
  uart_rx_if.master  rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic                 vld_q, vld_d, err_q, err_d, busy_q;
  logic                 par_bad_q, par_bad_d;
  logic                 cnt_end;

  uart_sync2 #(.RST_VAL(IDLE_LVL)) u_sync (
    .clk   (fpga_clk),
    .rst_n (nrst),
    .d     (rx.sin),
    .q     (s)
  );

  assign cnt_end = (cnt_q == CNT_LAST);

  always_ff @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      busy_q    <= (state_d != IDLE);
      par_bad_q <= par_bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    sh_d      = sh_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    par_bad_d = par_bad_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s != IDLE_LVL) state_d = START;
      end
      START: begin
        // start-bit centre: a line back at idle here was only a glitch
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = (s == IDLE_LVL) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          sh_d  = {s, sh_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_end) begin
          cnt_d     = '0;
          par_bad_d = s ^ (^sh_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (s == IDLE_LVL) begin
            state_d = IDLE;
            if (par_bad_q) begin
              err_d = 1'b1;
            end else begin
              vld_d  = 1'b1;
              dout_d = sh_q;
            end
          end else begin
            err_d   = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        // hold off until the line returns to idle so a break cannot retrigger
        cnt_d = '0;
        if (s == IDLE_LVL) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx.dout      = dout_q;
  assign rx.rx_valid  = vld_q;
  assign rx.frame_err = err_q;
  assign rx.busy_rx   = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frame generator, event scoreboard and per-cycle output compare.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // nominal sin-fall to rx_valid latency, one extra bit time when parity is present
  localparam int NOM = 2 + C/2 + (9 + (PAR ? 1 : 0)) * C;

  typedef struct {
    int         t0;
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic fpga_clk = 1'b0;
  logic nrst     = 1'b0;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  exp_t q[$];
  exp_t e;
  int   lat;
  logic [7:0] m_dout = 8'h00;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .rx       (bus)
  );

  always #5 fpga_clk = ~fpga_clk;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input int v);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: value %0d (cycle %0d)", nm, v, cyc);
  endtask

  // aborted frames leave no trace
  always @(negedge nrst) begin
    q.delete();
    m_dout = 8'h00;
  end

  always @(negedge fpga_clk) begin
    if (nrst) begin
      chk("exclusive", {31'd0, bus.rx_valid & bus.frame_err}, 32'd0);
      if (bus.rx_valid || bus.frame_err) begin
        if (q.size() == 0) begin
          miss("unexpected_pulse", int'(bus.frame_err));
        end else begin
          e = q.pop_front();
          chk("pulse_kind_err", {31'd0, bus.frame_err}, {31'd0, e.is_err});
          lat = cyc - e.t0;
          n_cmp++;
          if (lat < NOM - 1 || lat > NOM + 1) begin
            n_bad++;
            $display("FAIL latency: got %0d required %0d..%0d", lat, NOM - 1, NOM + 1);
          end
          if (!e.is_err) m_dout = e.data;
        end
      end
      chk("dout", {24'd0, bus.dout}, {24'd0, m_dout});
      if (q.size() > 0 && (cyc - q[0].t0) > NOM + 1) begin
        miss("missing_pulse", q[0].t0);
        void'(q.pop_front());
      end
    end
  end

  // drive one bit for one bit time; callers stay in the phase just after a rising edge
  task automatic drv(input logic v);
    bus.sin = v;
    repeat (C) @(posedge fpga_clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.sin = IDLE_LVL;
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip);
    exp_t x;
    x.t0     = cyc;
    x.is_err = !stop || pflip;
    x.data   = d;
    q.push_back(x);
    drv(1'b0);
    for (int i = 0; i < 8; i++) drv(d[i]);
    if (PAR) drv((^d) ^ pflip);
    drv(stop);
  endtask

  initial begin
    logic [7:0] d;
    bit         st, pf;
    int         seen;
    bus.sin = 1'b1;
    repeat (3) @(posedge fpga_clk);
    #1;
    chk("rst_dout", {24'd0, bus.dout}, 32'h00);
    chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_rx}, 32'd0);
    chk("rst_err", {31'd0, bus.frame_err}, 32'd0);
    nrst = 1'b1;
    idle(4);

    // back-to-back stream EE.., 95.., 78..
    fork
      send_frame(8'hEE, 1'b1, 1'b0);
      begin
        repeat (20) @(posedge fpga_clk);
        #2;
        chk("busy_midframe", {31'd0, bus.busy_rx}, 32'd1);
      end
    join
    send_frame(8'hEE, 1'b1, 1'b0);
    chk("dout_ee", {24'd0, bus.dout}, 32'hEE);
    send_frame(8'h95, 1'b1, 1'b0);
    send_frame(8'h95, 1'b1, 1'b0);
    chk("dout_95", {24'd0, bus.dout}, 32'h95);
    send_frame(8'h78, 1'b1, 1'b0);
    chk("dout_78", {24'd0, bus.dout}, 32'h78);
    idle(2 * C);
    chk("busy_after", {31'd0, bus.busy_rx}, 32'd0);

    // glitch shorter than half a bit
    bus.sin = 1'b0;
    repeat (2) @(posedge fpga_clk);
    #1;
    bus.sin = 1'b1;
    seen = 0;
    for (int i = 0; i < C/2 + 3; i++) begin
      @(posedge fpga_clk);
      #1;
      if (bus.busy_rx) seen = 1;
    end
    chk("glitch_busy_rose", seen, 1);
    chk("glitch_busy_fell", {31'd0, bus.busy_rx}, 32'd0);
    chk("glitch_dout", {24'd0, bus.dout}, 32'h78);
    idle(C);

    // bad stop bit followed by a held-low line
    send_frame(8'h5A, 1'b0, 1'b0);
    drv(1'b0); drv(1'b0); drv(1'b0);
    chk("brk_busy", {31'd0, bus.busy_rx}, 32'd1);
    chk("brk_dout", {24'd0, bus.dout}, 32'h78);
    idle(C);
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("dout_a5", {24'd0, bus.dout}, 32'hA5);
    idle(C);

    // reset during data bit 4
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (C + 4*C + 3) @(posedge fpga_clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_dout", {24'd0, bus.dout}, 32'h00);
        chk("midrst_busy", {31'd0, bus.busy_rx}, 32'd0);
        chk("midrst_valid", {31'd0, bus.rx_valid}, 32'd0);
        repeat (3) @(posedge fpga_clk);
        #2;
        nrst = 1'b1;
      end
    join
    idle(C);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("dout_3c", {24'd0, bus.dout}, 32'h3C);
    idle(C);

    if (PAR) begin
      send_frame(8'h03, 1'b1, 1'b1);
      chk("par_bad_dout", {24'd0, bus.dout}, 32'h3C);
      idle(C);
      send_frame(8'h03, 1'b1, 1'b0);
      chk("par_ok_dout", {24'd0, bus.dout}, 32'h03);
      idle(C);
    end

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(7) != 0);
      pf = PAR && ($urandom_range(7) == 0);
      send_frame(d, st, pf);
      if (!st) begin
        repeat ($urandom_range(3)) drv(1'b0);
        idle(C + $urandom_range(C));
      end else if ($urandom_range(1) == 1) begin
        idle($urandom_range(20));
      end
    end

    idle(NOM + 20);
    while (q.size() > 0) begin
      miss("undelivered", q[0].t0);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
